millis_timer: RTL and testbench

MILLIS_TIMER -- requirements
Module: millis_timer

---
 rtl/millis_timer_pkg.sv | 35 +++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/millis_timer.sv | 162 ++++++++++++++++
 tb/tb_millis_timer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/millis_timer_pkg.sv
// ---------------------------------------------------------------------------
// millis_timer_pkg
//   Shared types and constants for the millis_timer block:
//     state_t   - FSM state encoding (IDLE, RUN, PAUSE, DONE)
//     bcd_t     - one 4-bit BCD digit
//     DIGIT_MAX - largest value a decade holds before carrying
//     to_bcd()  - elaboration-time integer to packed BCD (up to 6 digits),
//                 used only to build comparison constants, never in logic
// ---------------------------------------------------------------------------
package millis_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

  function automatic logic [23:0] to_bcd(input int unsigned value);
    logic [23:0]  result;
    int unsigned  rem;
    result = '0;
    rem    = value;
    for (int i = 0; i < 6; i++) begin
      result[i*4 +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
//   One decade (0..9) of a ripple-carry BCD counter.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset (digit -> 0)
//     i_en     count enable for this cycle
//     i_clr    synchronous clear, wins over i_en
//     i_cin    carry in (digit 0 ties this high)
//     o_cout   carry out: this digit is at 9 and is being asked to count
//     o_digit  current digit value
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import millis_timer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_cin,
  output logic o_cout,
  output bcd_t o_digit
);

  bcd_t r_digit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= '0;
    end else if (i_clr) begin
      r_digit <= '0;
    end else if (i_en && i_cin) begin
      r_digit <= (r_digit == DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign o_cout  = i_cin && (r_digit == DIGIT_MAX);
  assign o_digit = r_digit;

endmodule

// File: rtl/millis_timer.sv
// ---------------------------------------------------------------------------
// millis_timer
//   Prescaled BCD stopwatch/timer with start, pause, clear and optional lap.
//   Optional feature macro: MILLIS_TIMER_LAP_EN (lap capture register).
//   Parameters: CLK_HZ, TICK_HZ (DIV = CLK_HZ/TICK_HZ >= 2), DIGITS (1..6),
//               MAX_COUNT (1..10^DIGITS-1), WRAP (0 = stop, 1 = roll over).
//   Ports:
//     i_clk         clock, rising edge
//     i_rst_n       asynchronous active-low reset
//     i_start       start / resume request (IDLE or PAUSE -> RUN)
//     i_stop        pause request (RUN -> PAUSE)
//     i_clear       clear to IDLE with count and prescaler zeroed
//     i_lap         lap capture request (only with MILLIS_TIMER_LAP_EN)
//     o_count       packed BCD count, digit 0 in [3:0]
//     o_running     high while in RUN
//     o_done        WRAP=0: high in DONE; WRAP=1: one-cycle rollover pulse
//     o_tick        one-cycle pulse following each count increment
//     o_lap_count   captured count (constant 0 without the lap feature)
// ---------------------------------------------------------------------------
module millis_timer
  import millis_timer_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1000,
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 99,
  parameter int WRAP      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_clear,
  input  logic                  i_lap,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_tick,
  output logic [4*DIGITS-1:0]   o_lap_count
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W   = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_TERM = PW'(DIV - 1);
  localparam logic [W-1:0]  MAX_BCD    = W'(to_bcd(MAX_COUNT));
  localparam logic [W-1:0]  PRE_MAX_BCD = W'(to_bcd(MAX_COUNT - 1));

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_next;
  logic            r_tick;
  logic            r_wrap_pulse;

  logic [W-1:0]    w_count;
  logic [DIGITS:0] w_carry;
  logic            w_term;
  logic            w_inc;
  logic            w_wrap_clr;
  logic            w_digit_clr;

  // An increment happens only on a terminal prescaler edge in RUN that is
  // not pre-empted by Clear or Stop.
  assign w_term      = (r_presc == PRESC_TERM);
  assign w_inc       = (r_state == ST_RUN) && !i_clear && !i_stop && w_term;
  // Rollover from MAX_COUNT: MAX_COUNT need not be all nines, so the digits
  // are cleared explicitly instead of relying on the natural carry.
  assign w_wrap_clr  = (WRAP != 0) && w_inc && (w_count == MAX_BCD);
  assign w_digit_clr = i_clear || w_wrap_clr;

  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_counter u_digit (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_inc),
        .i_clr   (w_digit_clr),
        .i_cin   (w_carry[gi]),
        .o_cout  (w_carry[gi+1]),
        .o_digit (w_count[gi*4 +: 4])
      );
    end
  endgenerate

  logic w_unused_carry;
  assign w_unused_carry = w_carry[DIGITS];

  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!i_stop && i_start) w_state_next = ST_RUN;
        ST_RUN: begin
          if (i_stop) begin
            w_state_next = ST_PAUSE;
          end else if ((WRAP == 0) && w_inc && (w_count == PRE_MAX_BCD)) begin
            // The increment that lands on MAX_COUNT ends the run.
            w_state_next = ST_DONE;
          end
        end
        ST_PAUSE: if (!i_stop && i_start) w_state_next = ST_RUN;
        ST_DONE:  w_state_next = ST_DONE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_presc_next = r_presc;
    if (i_clear) begin
      w_presc_next = '0;
    end else if ((r_state == ST_RUN) && !i_stop) begin
      w_presc_next = w_term ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_tick       <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_tick       <= w_inc;
      r_wrap_pulse <= w_wrap_clr;
    end
  end

  assign o_count   = w_count;
  assign o_running = (r_state == ST_RUN);
  assign o_tick    = r_tick;
  assign o_done    = (WRAP != 0) ? r_wrap_pulse : (r_state == ST_DONE);

`ifdef MILLIS_TIMER_LAP_EN
  logic [W-1:0] r_lap_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lap_count <= '0;
    end else if (i_clear) begin
      r_lap_count <= '0;
    end else if (i_lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
      r_lap_count <= w_count;
    end
  end

  assign o_lap_count = r_lap_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = i_lap;
  assign o_lap_count  = '0;
`endif

endmodule

// File: tb/tb_millis_timer.sv
module tb_millis_timer;

  logic       clk;
  logic       rst_n;
  // dut0: DIV=10, MAX_COUNT=99, WRAP=0
  logic       start0, stop0, clear0, lap0;
  logic [7:0] count0, lap_count0;
  logic       running0, done0, tick0;
  // dut1: DIV=10, MAX_COUNT=12, WRAP=1
  logic       start1, stop1, clear1, lap1;
  logic [7:0] count1, lap_count1;
  logic       running1, done1, tick1;

  int checks;
  int failures;

`ifdef MILLIS_TIMER_LAP_EN
  localparam logic [7:0] LAP_EXP = 8'h25;
`else
  localparam logic [7:0] LAP_EXP = 8'h00;
`endif

  millis_timer #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(2), .MAX_COUNT(99), .WRAP(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_stop(stop0),
    .i_clear(clear0), .i_lap(lap0), .o_count(count0), .o_running(running0),
    .o_done(done0), .o_tick(tick0), .o_lap_count(lap_count0)
  );

  millis_timer #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(2), .MAX_COUNT(12), .WRAP(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_stop(stop1),
    .i_clear(clear1), .i_lap(lap1), .o_count(count1), .o_running(running1),
    .o_done(done1), .o_tick(tick1), .o_lap_count(lap_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end else begin
      $display("ok   %s value=%0h", tag, act);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] wrap_seq [13];

  initial begin
    checks   = 0;
    failures = 0;
    wrap_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h00};
    rst_n  = 1'b0;
    start0 = 0; stop0 = 0; clear0 = 0; lap0 = 0;
    start1 = 0; stop1 = 0; clear1 = 0; lap1 = 0;

    // Reset state
    #2;
    check("rst_count0",   count0,     0);
    check("rst_running0", running0,   0);
    check("rst_done0",    done0,      0);
    check("rst_tick0",    tick0,      0);
    check("rst_lap0",     lap_count0, 0);
    check("rst_count1",   count1,     0);
    #10 rst_n = 1'b1;
    step(1);

    // WRAP=1, MAX_COUNT=12: 13 ticks, last one rolls to 00 with Done pulse
    start1 = 1; step(1); start1 = 0;
    check("wrap_running", running1, 1);
    for (int k = 0; k < 13; k++) begin
      step(10);
      check($sformatf("wrap_count_%0d", k + 1), count1, wrap_seq[k]);
      check($sformatf("wrap_tick_%0d", k + 1), tick1, 1);
      check($sformatf("wrap_done_%0d", k + 1), done1, (k == 12) ? 1 : 0);
      check($sformatf("wrap_run_%0d", k + 1), running1, 1);
    end
    step(1);
    check("wrap_done_pulse_end", done1, 0);
    check("wrap_tick_end", tick1, 0);
    clear1 = 1; step(1); clear1 = 0;
    check("wrap_clear_run", running1, 0);

    // WRAP=0: Start sampled at cycle 0, first Tick at cycle 10
    start0 = 1; step(1); start0 = 0;
    check("start_running", running0, 1);
    step(9);
    check("pre_tick_count", count0, 8'h00);
    check("pre_tick_tick",  tick0,  0);
    step(1);
    check("first_tick",  tick0,  1);
    check("first_count", count0, 8'h01);
    step(1);
    check("first_tick_end", tick0, 0);

    // Lap at count 25 (cycle 250)
    step(239);
    check("lap_at_count", count0, 8'h25);
    lap0 = 1; step(1); lap0 = 0;
    check("lap_captured", lap_count0, LAP_EXP);
    step(10);
    check("lap_count_advanced", count0, 8'h26);
    check("lap_held", lap_count0, LAP_EXP);

    // Reach terminal count 99 at cycle 990
    step(729);
    check("max_count",   count0,   8'h99);
    check("max_tick",    tick0,    1);
    check("max_done",    done0,    1);
    check("max_running", running0, 0);
    step(20);
    start0 = 1; step(1); start0 = 0;
    check("done_hold_count", count0, 8'h99);
    check("done_hold_done",  done0,  1);
    check("done_hold_tick",  tick0,  0);
    clear0 = 1; step(1); clear0 = 0;
    check("clear_count", count0, 8'h00);
    check("clear_done",  done0,  0);
    check("clear_lap",   lap_count0, 0);

    // Pause after 4 prescaler advances, hold 50, resume: Tick 6 cycles later
    start0 = 1; step(1); start0 = 0;
    step(4);
    stop0 = 1; step(1); stop0 = 0;
    check("pause_running", running0, 0);
    step(50);
    check("pause_hold_count", count0, 8'h00);
    start0 = 1; step(1); start0 = 0;
    check("resume_running", running0, 1);
    step(5);
    check("resume_pre_tick", tick0, 0);
    step(1);
    check("resume_tick",  tick0,  1);
    check("resume_count", count0, 8'h01);

    // Stop on the terminal prescaler edge: PAUSE, no increment
    step(9);
    stop0 = 1; step(1); stop0 = 0;
    check("stop_term_tick",    tick0,    0);
    check("stop_term_count",   count0,   8'h01);
    check("stop_term_running", running0, 0);
    start0 = 1; step(1); start0 = 0;
    step(1);
    check("stop_term_resume_tick",  tick0,  1);
    check("stop_term_resume_count", count0, 8'h02);

    // Clear colliding with the terminal increment at count 37
    clear0 = 1; step(1); clear0 = 0;
    start0 = 1; step(1); start0 = 0;
    step(379);
    check("clr_term_pre_count", count0, 8'h37);
    clear0 = 1; step(1); clear0 = 0;
    check("clr_term_count",   count0,   8'h00);
    check("clr_term_tick",    tick0,    0);
    check("clr_term_done",    done0,    0);
    check("clr_term_running", running0, 0);
    step(15);
    check("clr_term_idle", count0, 8'h00);

    // Asynchronous reset mid-run, between edges
    start0 = 1; step(1); start0 = 0;
    step(25);
    check("async_pre_count", count0, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("async_count",   count0,   0);
    check("async_running", running0, 0);
    check("async_done",    done0,    0);
    check("async_tick",    tick0,    0);
    check("async_lap",     lap_count0, 0);
    #3 rst_n = 1'b1;
    step(2);
    check("async_after_idle", running0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
